// File: rtl/adc_config_scheduler.sv
// Sole driver of the ADC 3-wire serial port and calibration pins: arbitrates init/host
// register writes and calibration requests, shifts 32-bit frames, runs the cal handshake.
module adc_config_scheduler #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned GAP_CYCLES  = 8,
   parameter int unsigned CAL_PULSE   = 4,
   parameter int unsigned CAL_TIMEOUT = 1024
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        InitReq,
   input  logic [3:0]  InitAddr,
   input  logic [15:0] InitData,
   output logic        InitAck,
   input  logic        HostReq,
   input  logic [3:0]  HostAddr,
   input  logic [15:0] HostData,
   output logic        HostAck,
   input  logic        CalReq,
   output logic        CalDone,
   output logic        CalTimeout,
   output logic        Busy,
   output logic        OutSclk,
   output logic        OutSdata,
   output logic        OutSelect,
   output logic        OutCal,
   input  logic        InCalRunning
);
   localparam int unsigned TO_W   = $clog2(CAL_TIMEOUT + 1);
   localparam int unsigned PH_MAX = (CLK_DIV > GAP_CYCLES) ?
                                    ((CLK_DIV > CAL_PULSE) ? CLK_DIV : CAL_PULSE) :
                                    ((GAP_CYCLES > CAL_PULSE) ? GAP_CYCLES : CAL_PULSE);
   localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
   localparam int unsigned CNT_W  = (TO_W > PH_W) ? TO_W : PH_W;

   typedef enum logic [2:0] {
      IDLE, LOAD, SHIFT, TAIL, GAP, CAL_PULSE_ST, CAL_WAIT_HI, CAL_WAIT_LO
   } stateT;

   stateT             state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic [5:0]        halfIdx, halfIdxNext, halfInc;
   logic [31:0]       frame, frameNext;
   logic              calSync1, calSync2;
   logic              selectNext, sclkNext, sdataNext, calNext, busyNext;
   logic              initAckNext, hostAckNext, calDoneNext, calTimeoutNext;

   // Next-state and next-output decode; outputs are registered from these
   always_comb begin
      stateNext      = state;
      cntNext        = cnt + 1'b1;
      halfIdxNext    = halfIdx;
      halfInc        = halfIdx + 6'd1;
      frameNext      = frame;
      selectNext     = 1'b1;
      sclkNext       = 1'b0;
      sdataNext      = OutSdata;
      calNext        = 1'b0;
      initAckNext    = 1'b0;
      hostAckNext    = 1'b0;
      calDoneNext    = 1'b0;
      calTimeoutNext = 1'b0;
      case (state)
         IDLE: begin
            cntNext = '0;
            if (Enable) begin
               if (InitReq) begin
                  frameNext   = {12'h001, InitAddr, InitData};
                  initAckNext = 1'b1;
                  stateNext   = LOAD;
                  selectNext  = 1'b0;
                  sdataNext   = frameNext[31];
               end else if (CalReq) begin
                  stateNext = CAL_PULSE_ST;
                  calNext   = 1'b1;
               end else if (HostReq) begin
                  frameNext   = {12'h001, HostAddr, HostData};
                  hostAckNext = 1'b1;
                  stateNext   = LOAD;
                  selectNext  = 1'b0;
                  sdataNext   = frameNext[31];
               end
            end
         end
         LOAD: begin
            selectNext = 1'b0;
            sdataNext  = frame[31];
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               stateNext   = SHIFT;
               cntNext     = '0;
               halfIdxNext = '0;
            end
         end
         SHIFT: begin
            selectNext = 1'b0;
            sclkNext   = halfIdx[0];
            // Each half-period ends on cnt wrap; data moves only when a low phase starts
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               cntNext = '0;
               if (halfIdx == 6'd63) begin
                  stateNext = TAIL;
                  sclkNext  = 1'b0;
               end else begin
                  halfIdxNext = halfInc;
                  sclkNext    = halfInc[0];
                  if (!halfInc[0])
                     sdataNext = frame[5'd31 - halfInc[5:1]];
               end
            end
         end
         TAIL: begin
            selectNext = 1'b0;
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               stateNext  = GAP;
               selectNext = 1'b1;
               cntNext    = '0;
            end
         end
         GAP: begin
            if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
               stateNext = IDLE;
               cntNext   = '0;
            end
         end
         CAL_PULSE_ST: begin
            calNext = 1'b1;
            if (cnt == CNT_W'(CAL_PULSE - 1)) begin
               stateNext = CAL_WAIT_HI;
               calNext   = 1'b0;
               cntNext   = '0;
            end
         end
         CAL_WAIT_HI: begin
            if (calSync2) begin
               stateNext = CAL_WAIT_LO;
               cntNext   = '0;
            end else if (cnt == CNT_W'(CAL_TIMEOUT - 1)) begin
               stateNext      = IDLE;
               calTimeoutNext = 1'b1;
            end
         end
         CAL_WAIT_LO: begin
            if (!calSync2) begin
               stateNext   = IDLE;
               calDoneNext = 1'b1;
            end else if (cnt == CNT_W'(CAL_TIMEOUT - 1)) begin
               stateNext      = IDLE;
               calTimeoutNext = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
      busyNext = (stateNext != IDLE);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         halfIdx    <= '0;
         frame      <= '0;
         calSync1   <= 1'b0;
         calSync2   <= 1'b0;
         OutSelect  <= 1'b1;
         OutSclk    <= 1'b0;
         OutSdata   <= 1'b0;
         OutCal     <= 1'b0;
         InitAck    <= 1'b0;
         HostAck    <= 1'b0;
         CalDone    <= 1'b0;
         CalTimeout <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         state      <= stateNext;
         cnt        <= cntNext;
         halfIdx    <= halfIdxNext;
         frame      <= frameNext;
         calSync1   <= InCalRunning;
         calSync2   <= calSync1;
         OutSelect  <= selectNext;
         OutSclk    <= sclkNext;
         OutSdata   <= sdataNext;
         OutCal     <= calNext;
         InitAck    <= initAckNext;
         HostAck    <= hostAckNext;
         CalDone    <= calDoneNext;
         CalTimeout <= calTimeoutNext;
         Busy       <= busyNext;
      end
   end
endmodule

// File: tb/tb_adc_config_scheduler.sv
// Bench for adc_config_scheduler: decodes serial frames off the pins, models the ADC cal handshake.
module tb_adc_config_scheduler;
   localparam int CLK_DIV = 4;
   localparam int GAP_CYCLES = 8;
   localparam int CAL_PULSE = 4;
   localparam int CAL_TIMEOUT = 1024;

   logic        Clock, Reset, Enable;
   logic        InitReq, HostReq, CalReq, InCalRunning;
   logic [3:0]  InitAddr, HostAddr;
   logic [15:0] InitData, HostData;
   logic        InitAck, HostAck, CalDone, CalTimeout, Busy;
   logic        OutSclk, OutSdata, OutSelect, OutCal;

   adc_config_scheduler #(
      .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .CAL_PULSE(CAL_PULSE), .CAL_TIMEOUT(CAL_TIMEOUT)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable),
      .InitReq(InitReq), .InitAddr(InitAddr), .InitData(InitData), .InitAck(InitAck),
      .HostReq(HostReq), .HostAddr(HostAddr), .HostData(HostData), .HostAck(HostAck),
      .CalReq(CalReq), .CalDone(CalDone), .CalTimeout(CalTimeout), .Busy(Busy),
      .OutSclk(OutSclk), .OutSdata(OutSdata), .OutSelect(OutSelect), .OutCal(OutCal),
      .InCalRunning(InCalRunning)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   int passCnt = 0;
   int totalCnt = 0;

   // Pin-level observer state
   logic        prevSel = 1'b1, prevSclk = 1'b0;
   logic        prevInitAck = 1'b0, prevHostAck = 1'b0, prevCalDone = 1'b0, prevCalTo = 1'b0;
   bit          inFrame = 0;
   logic [31:0] shiftReg = '0;
   int bitCnt = 0, lowCnt = 0, highRun = 0, lastGap = 0, sclkRises = 0;
   int initAcks = 0, hostAcks = 0, calDones = 0, calTimeouts = 0, widePulses = 0;
   logic [31:0] frameQ[$];
   int          bitsQ[$];
   int          lowQ[$];

   function automatic logic [31:0] frameOf(input logic [3:0] a, input logic [15:0] d);
      return {12'h001, a, d};
   endfunction

   // Advance one cycle, sample just after the edge and update the pin observer
   task automatic tick();
      @(posedge Clock);
      #1;
      if (Reset) begin
         inFrame = 0;
      end else begin
         if (prevSel && !OutSelect) begin
            inFrame = 1; bitCnt = 0; lowCnt = 0; shiftReg = '0; lastGap = highRun;
         end
         if (OutSelect) highRun++; else highRun = 0;
         if (!OutSelect && inFrame) lowCnt++;
         if (!prevSclk && OutSclk) begin
            sclkRises++;
            if (inFrame) begin
               shiftReg = {shiftReg[30:0], OutSdata};
               bitCnt++;
            end
         end
         if (!prevSel && OutSelect && inFrame) begin
            frameQ.push_back(shiftReg); bitsQ.push_back(bitCnt); lowQ.push_back(lowCnt);
            inFrame = 0;
         end
      end
      prevSel = OutSelect;
      prevSclk = OutSclk;
      if (InitAck) initAcks++;
      if (HostAck) hostAcks++;
      if (CalDone) calDones++;
      if (CalTimeout) calTimeouts++;
      if ((InitAck && prevInitAck) || (HostAck && prevHostAck) ||
          (CalDone && prevCalDone) || (CalTimeout && prevCalTo)) widePulses++;
      prevInitAck = InitAck; prevHostAck = HostAck; prevCalDone = CalDone; prevCalTo = CalTimeout;
   endtask

   // Wait for the next completed frame; x values signal that none arrived in time
   task automatic wait_frame(input int n0, output logic [31:0] w, output int bits, output int low);
      for (int i = 0; i < 600 && frameQ.size() == n0; i++) tick();
      if (frameQ.size() > n0) begin
         w = frameQ[n0]; bits = bitsQ[n0]; low = lowQ[n0];
      end else begin
         w = 'x; bits = -1; low = -1;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && Busy; i++) tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1; Enable = 1'b1; InitReq = 0; HostReq = 0; CalReq = 0; InCalRunning = 0;
      InitAddr = '0; InitData = '0; HostAddr = '0; HostData = '0;
      repeat (3) tick();
      totalCnt++;
      if ({OutSelect, OutSclk, OutSdata, OutCal, Busy, InitAck, HostAck, CalDone, CalTimeout} !== 9'b1_0000_0000)
         $display("FAIL reset_in: pins=%b required=100000000",
                  {OutSelect, OutSclk, OutSdata, OutCal, Busy, InitAck, HostAck, CalDone, CalTimeout});
      else passCnt++;
      Reset = 1'b0;
      repeat (2) tick();
      totalCnt++;
      if ({OutSelect, OutSclk, OutCal, Busy} !== 4'b1000)
         $display("FAIL reset_out: pins=%b required=1000", {OutSelect, OutSclk, OutCal, Busy});
      else passCnt++;
   endtask

   task automatic test_init_frame();
      logic [31:0] w; int bits, low, n0;
      n0 = frameQ.size();
      InitAddr = 4'h1; InitData = 16'hB2FF; InitReq = 1'b1;
      tick();
      totalCnt++;
      if ({InitAck, HostAck} !== 2'b10) $display("FAIL init_ack: acks=%b required=10", {InitAck, HostAck});
      else passCnt++;
      InitReq = 1'b0;
      tick();
      totalCnt++;
      if (InitAck !== 1'b0) $display("FAIL init_ack_width: InitAck=%b required=0", InitAck);
      else passCnt++;
      wait_frame(n0, w, bits, low);
      totalCnt++;
      if (w !== frameOf(4'h1, 16'hB2FF)) $display("FAIL init_word: got=%h required=%h", w, frameOf(4'h1, 16'hB2FF));
      else passCnt++;
      totalCnt++;
      if (low !== 66 * CLK_DIV) $display("FAIL init_select_low: got=%0d required=%0d", low, 66 * CLK_DIV);
      else passCnt++;
      wait_idle();
      totalCnt++;
      if (highRun < GAP_CYCLES) $display("FAIL init_gap: select high %0d required>=%0d", highRun, GAP_CYCLES);
      else passCnt++;
   endtask

   task automatic test_priority();
      logic [31:0] w; int bits, low, n0; bit seen;
      n0 = frameQ.size();
      InitAddr = 4'h5; InitData = 16'(($urandom));
      HostAddr = 4'h3; HostData = 16'h7FFF;
      InitReq = 1'b1; HostReq = 1'b1;
      tick();
      totalCnt++;
      if ({InitAck, HostAck} !== 2'b10) $display("FAIL prio_first: acks=%b required=10", {InitAck, HostAck});
      else passCnt++;
      InitReq = 1'b0;
      seen = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
         tick();
         if (HostAck) seen = 1;
      end
      HostReq = 1'b0;
      totalCnt++;
      if (!(seen && frameQ.size() == n0 + 1 && lastGap >= GAP_CYCLES))
         $display("FAIL prio_host_after_gap: seen=%0d frames=%0d gap=%0d required 1/%0d/>=%0d",
                  seen, frameQ.size() - n0, lastGap, 1, GAP_CYCLES);
      else passCnt++;
      totalCnt++;
      if (frameQ.size() > n0 && frameQ[n0] !== frameOf(4'h5, InitData))
         $display("FAIL prio_init_word: got=%h required=%h", frameQ[n0], frameOf(4'h5, InitData));
      else passCnt++;
      wait_frame(n0 + 1, w, bits, low);
      totalCnt++;
      if (w !== 32'h0013_7FFF) $display("FAIL prio_host_word: got=%h required=00137fff", w);
      else passCnt++;
      wait_idle();
   endtask

   task automatic test_random_frames();
      logic [31:0] w, exp; int bits, low, n0; logic [3:0] a; logic [15:0] d; bit useInit;
      for (int t = 0; t < 5; t++) begin
         n0 = frameQ.size();
         a = 4'($urandom); d = 16'($urandom); useInit = 1'($urandom);
         exp = frameOf(a, d);
         if (useInit) begin InitAddr = a; InitData = d; InitReq = 1'b1; end
         else begin HostAddr = a; HostData = d; HostReq = 1'b1; end
         tick();
         InitReq = 1'b0; HostReq = 1'b0;
         wait_frame(n0, w, bits, low);
         totalCnt++;
         if (w !== exp || bits !== 32 || low !== 66 * CLK_DIV)
            $display("FAIL rand_frame%0d: word=%h bits=%0d low=%0d required %h/32/%0d", t, w, bits, low, exp, 66 * CLK_DIV);
         else passCnt++;
         wait_idle();
      end
   endtask

   task automatic test_cal();
      int riseAt, hold, fallK, doneAt, calHigh, rises0, done0, to0; bit selLow;
      riseAt = int'($urandom_range(30, 50));
      hold = int'($urandom_range(80, 120));
      fallK = riseAt + hold + 1;
      done0 = calDones; to0 = calTimeouts; rises0 = sclkRises;
      CalReq = 1'b1;
      tick();
      CalReq = 1'b0;
      calHigh = OutCal ? 1 : 0;
      selLow = 0; doneAt = -1;
      for (int k = 1; k < 400 && doneAt < 0; k++) begin
         InCalRunning = (k > riseAt && k < fallK);
         tick();
         if (OutCal) calHigh++;
         if (!OutSelect) selLow = 1;
         if (CalDone) doneAt = k;
      end
      InCalRunning = 1'b0;
      repeat (3) tick();
      totalCnt++;
      if (calHigh !== CAL_PULSE) $display("FAIL cal_pulse_len: got=%0d required=%0d", calHigh, CAL_PULSE);
      else passCnt++;
      totalCnt++;
      if (doneAt < fallK + 1 || doneAt > fallK + 4)
         $display("FAIL cal_done_time: got=%0d required %0d..%0d", doneAt, fallK + 1, fallK + 4);
      else passCnt++;
      totalCnt++;
      if (calDones - done0 !== 1 || calTimeouts - to0 !== 0)
         $display("FAIL cal_done_count: done=%0d timeout=%0d required 1/0", calDones - done0, calTimeouts - to0);
      else passCnt++;
      totalCnt++;
      if (sclkRises !== rises0 || selLow) $display("FAIL cal_serial_quiet: sclk rises=%0d sel_low=%0d required 0/0",
                                                  sclkRises - rises0, selLow);
      else passCnt++;
   endtask

   task automatic test_cal_timeout();
      int toAt, done0, to0; logic busyAt;
      done0 = calDones; to0 = calTimeouts;
      InCalRunning = 1'b0;
      CalReq = 1'b1;
      tick();
      CalReq = 1'b0;
      for (int i = 0; i < 20 && OutCal; i++) tick();
      toAt = -1; busyAt = 1'bx;
      for (int n = 1; n < 1200 && toAt < 0; n++) begin
         tick();
         if (CalTimeout) begin toAt = n; busyAt = Busy; end
      end
      tick();
      totalCnt++;
      if (toAt !== CAL_TIMEOUT) $display("FAIL cal_timeout_time: got=%0d required=%0d", toAt, CAL_TIMEOUT);
      else passCnt++;
      totalCnt++;
      if (busyAt !== 1'b0 || Busy !== 1'b0) $display("FAIL cal_timeout_busy: got=%b%b required=00", busyAt, Busy);
      else passCnt++;
      totalCnt++;
      if (calTimeouts - to0 !== 1 || calDones - done0 !== 0)
         $display("FAIL cal_timeout_count: timeout=%0d done=%0d required 1/0", calTimeouts - to0, calDones - done0);
      else passCnt++;
   endtask

   task automatic test_reset_midframe();
      int n0, acks0; bit reached;
      n0 = frameQ.size();
      HostAddr = 4'($urandom); HostData = 16'($urandom); HostReq = 1'b1;
      tick();
      HostReq = 1'b0;
      reached = 0;
      for (int i = 0; i < 400 && !reached; i++) begin
         tick();
         if (inFrame && bitCnt == 10) reached = 1;
      end
      #2 Reset = 1'b1;
      #1;
      totalCnt++;
      if (!reached || {OutSelect, OutSclk, OutCal, Busy} !== 4'b1000)
         $display("FAIL reset_midframe_pins: reached=%0d pins=%b required 1/1000", reached, {OutSelect, OutSclk, OutCal, Busy});
      else passCnt++;
      acks0 = initAcks + hostAcks + calDones + calTimeouts;
      repeat (3) tick();
      Reset = 1'b0;
      repeat (300) tick();
      totalCnt++;
      if (initAcks + hostAcks + calDones + calTimeouts !== acks0 || frameQ.size() !== n0 || Busy !== 1'b0)
         $display("FAIL reset_midframe_after: new_pulses=%0d new_frames=%0d busy=%b required 0/0/0",
                  initAcks + hostAcks + calDones + calTimeouts - acks0, frameQ.size() - n0, Busy);
      else passCnt++;
   endtask

   task automatic test_enable();
      logic [31:0] w; int bits, low, n0, acks0;
      n0 = frameQ.size();
      acks0 = hostAcks;
      Enable = 1'b0;
      HostAddr = 4'($urandom); HostData = 16'($urandom); HostReq = 1'b1;
      repeat (20) tick();
      totalCnt++;
      if (hostAcks !== acks0 || Busy !== 1'b0) $display("FAIL enable_block: acks=%0d busy=%b required 0/0", hostAcks - acks0, Busy);
      else passCnt++;
      Enable = 1'b1;
      tick();
      totalCnt++;
      if (HostAck !== 1'b1) $display("FAIL enable_grant: HostAck=%b required=1", HostAck);
      else passCnt++;
      HostReq = 1'b0;
      for (int i = 0; i < 400 && !(inFrame && bitCnt >= 5); i++) tick();
      Enable = 1'b0;
      wait_frame(n0, w, bits, low);
      totalCnt++;
      if (w !== frameOf(HostAddr, HostData) || bits !== 32)
         $display("FAIL enable_drop_frame: word=%h bits=%0d required %h/32", w, bits, frameOf(HostAddr, HostData));
      else passCnt++;
      acks0 = hostAcks;
      HostReq = 1'b1;
      repeat (30) tick();
      totalCnt++;
      if (hostAcks !== acks0 || Busy !== 1'b0) $display("FAIL enable_hold_idle: acks=%0d busy=%b required 0/0", hostAcks - acks0, Busy);
      else passCnt++;
      HostReq = 1'b0;
      Enable = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_pulse_widths();
      totalCnt++;
      if (widePulses !== 0) $display("FAIL pulse_width: multi-cycle pulses=%0d required=0", widePulses);
      else passCnt++;
   endtask

   initial begin
      test_reset();
      test_init_frame();
      test_priority();
      test_random_frames();
      test_cal();
      test_cal_timeout();
      test_reset_midframe();
      test_enable();
      test_pulse_widths();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
